// File: rtl/eqn_seq_cmp_if.sv
//------------------------------------------------------------------------------
// Module : eqn_seq_cmp_if
// Brief  : Start/busy/done handshake and result flags for the sequential comparator.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface eqn_seq_cmp_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             aeqb;
    logic             agtb;
    logic             altb;

    modport master (
        output start, a, b,
        input  busy, done, aeqb, agtb, altb
    );

    modport slave (
        input  start, a, b,
        output busy, done, aeqb, agtb, altb
    );
endinterface

`default_nettype wire

// File: rtl/eqn_seq_cmp.sv
//------------------------------------------------------------------------------
// Module : eqn_seq_cmp
// Brief  : MSB-first digit-serial magnitude/equality compare with early exit.
//          Define CMP_SIGNED_EN for two's-complement ordering.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module eqn_seq_cmp #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    eqn_seq_cmp_if.slave    bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NDIG - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_width
            $error("eqn_seq_cmp: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_aeqb;
    logic             r_agtb;
    logic             r_altb;

    logic [WIDTH-1:0] w_a_load;
    logic [WIDTH-1:0] w_b_load;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
`ifdef CMP_SIGNED_EN
    assign w_a_load = {~bus.a[WIDTH-1], bus.a[WIDTH-2:0]};
    assign w_b_load = {~bus.b[WIDTH-1], bus.b[WIDTH-2:0]};
`else
    assign w_a_load = bus.a;
    assign w_b_load = bus.b;
`endif

    assign w_a_dig = r_a[WIDTH-1 -: DIGIT];
    assign w_b_dig = r_b[WIDTH-1 -: DIGIT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_aeqb  <= 1'b0;
            r_agtb  <= 1'b0;
            r_altb  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= w_a_load;
                        r_b     <= w_b_load;
                        r_cnt   <= '0;
                        r_aeqb  <= 1'b0;
                        r_agtb  <= 1'b0;
                        r_altb  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_a_dig != w_b_dig) begin
                        r_agtb  <= (w_a_dig > w_b_dig);
                        r_altb  <= (w_a_dig < w_b_dig);
                        r_aeqb  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_cnt == C_LAST) begin
                        r_aeqb  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_a   <= r_a << DIGIT;
                        r_b   <= r_b << DIGIT;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.aeqb = r_aeqb;
    assign bus.agtb = r_agtb;
    assign bus.altb = r_altb;

endmodule

`default_nettype wire

// File: tb/tb_eqn_seq_cmp.sv
//------------------------------------------------------------------------------
// Module : tb_eqn_seq_cmp
// Brief  : Scoreboard bench for eqn_seq_cmp (WIDTH=16, DIGIT=2 plus a DIGIT=4 copy).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_eqn_seq_cmp;
    localparam logic [2:0] C_EQ = 3'b100;
    localparam logic [2:0] C_GT = 3'b010;
    localparam logic [2:0] C_LT = 3'b001;

    typedef struct {
        logic [2:0] flags;
        int         lat;
        int         acc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    eqn_seq_cmp_if #(.WIDTH(16)) bus ();
    eqn_seq_cmp_if #(.WIDTH(16)) bus4 ();

    eqn_seq_cmp #(.WIDTH(16), .DIGIT(2)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    eqn_seq_cmp #(.WIDTH(16), .DIGIT(4)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.done === 1'b1) begin
                chk("done_busy_excl", {31'd0, bus.busy}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("flags", {29'd0, bus.aeqb, bus.agtb, bus.altb}, {29'd0, e.flags});
                    chk("latency", cyc - e.acc, e.lat);
                end
            end else if (bus.busy === 1'b1) begin
                chk("flags_clear_in_run", {29'd0, bus.aeqb, bus.agtb, bus.altb}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] flags, input int lat);
        exp_t e;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.flags = flags;
        e.lat   = lat;
        e.acc   = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) return;
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] flags, input int lat);
        @(negedge clk);
        issue(a, b, flags, lat);
        wait_done(20);
    endtask

    initial begin
        int lat4;
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b1;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;

        // Async reset between edges
        #7 reset_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_flags", {29'd0, bus.aeqb, bus.agtb, bus.altb}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outputs", {27'd0, bus.busy, bus.done, bus.aeqb, bus.agtb, bus.altb}, 32'd0);

        run(16'hA5A5, 16'hA5A5, C_EQ, 8);
`ifdef CMP_SIGNED_EN
        run(16'h8000, 16'h7FFF, C_LT, 1);
        run(16'h4000, 16'h8000, C_GT, 1);
`else
        run(16'h8000, 16'h7FFF, C_GT, 1);
        run(16'h4000, 16'h8000, C_LT, 1);
`endif
        run(16'h0001, 16'h0003, C_LT, 8);
        run(16'h1234, 16'h1230, C_GT, 7);
        run(16'h0000, 16'h0000, C_EQ, 8);
        run(16'hFFFF, 16'hFFFE, C_GT, 8);
        run(16'h0C00, 16'h0800, C_GT, 3);

        // Start during RUN is ignored; start in DONE is taken immediately
        @(negedge clk);
        issue(16'hA5A5, 16'hA5A5, C_EQ, 8);
        @(negedge clk);
        @(negedge clk);
        bus.a     = 16'h0000;
        bus.b     = 16'hFFFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(20);
        issue(16'h0C00, 16'h0800, C_GT, 3);
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(20);
        @(negedge clk);
        chk("b2b_idle", {30'd0, bus.busy, bus.done}, 32'd0);

        // Reset during the third RUN cycle aborts without a done pulse
        @(negedge clk);
        issue(16'hA5A5, 16'hA5A5, C_EQ, 8);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_flags", {29'd0, bus.aeqb, bus.agtb, bus.altb}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        run(16'hA5A5, 16'hA5A5, C_EQ, 8);

        // DIGIT=4 variant: mismatch in the last of four digits
        @(negedge clk);
        bus4.a     = 16'h0001;
        bus4.b     = 16'h0003;
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        lat4 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus4.done === 1'b1) begin
                lat4 = i;
                break;
            end
        end
        chk("d4_latency", lat4, 4);
        chk("d4_flags", {29'd0, bus4.aeqb, bus4.agtb, bus4.altb}, {29'd0, C_LT});

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
